// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS instruction/data bus arbiter.
// Included by the watchdog and the arbiter top.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_READDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Wait-state counter for one bus transaction.
// Flags expiry on the wait cycle that reaches TIMEOUT_CYCLES.
module mips_bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  // The current wait cycle is the one that reaches the limit.
  assign expired = count && (r_cnt == LAST);

  // Count wait cycles; cleared while idle so each grant starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) r_cnt <= '0;
    else if (count)     r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master (instruction/data) to one-bus arbiter with watchdog timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed d priority.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              bus_error
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       w_d_req;
  logic       w_grant;
  logic       w_expired;
  logic       w_done;
  logic       w_pick_d;
  logic       r_bus_error;

  assign w_d_req = d_read || d_write;
  assign w_grant = (r_state != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_pref_d;

  assign w_pick_d = w_d_req && (!i_read || r_pref_d);

  // Remember who was served so the other master wins the next tie.
  always_ff @(posedge clk) begin
    if (reset)                            r_pref_d <= 1'b1;
    else if (r_state == IDLE && w_next != IDLE) r_pref_d <= (w_next == GRANT_I);
  end
`else
  assign w_pick_d = w_d_req;
`endif

  mips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!w_grant),
    .count  (w_grant && waitrequest),
    .expired(w_expired)
  );

  // A reset edge abandons the grant, so never report completion then.
  assign w_done = w_grant && !reset && (!waitrequest || w_expired);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset)                     r_bus_error <= 1'b0;
    else if (w_grant && w_expired) r_bus_error <= 1'b1;
  end

  assign bus_error = r_bus_error;

  // Next-state selection and bus/port output muxing.
  always_comb begin
    w_next        = r_state;
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = i_read;
    d_waitrequest = w_d_req;
    i_readdata    = readdata;
    d_readdata    = readdata;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d)    w_next = GRANT_D;
        else if (i_read) w_next = GRANT_I;
      end
      GRANT_I: begin
        address    = i_address;
        read       = i_read;
        byteenable = {BE_W{1'b1}};
        if (w_done) begin
          w_next        = IDLE;
          i_waitrequest = 1'b0;
          if (waitrequest) i_readdata = ERR_READDATA;
        end
      end
      GRANT_D: begin
        address    = d_address;
        read       = d_read && !d_write;
        write      = d_write;
        writedata  = d_writedata;
        byteenable = d_byteenable;
        if (w_done) begin
          w_next        = IDLE;
          d_waitrequest = 1'b0;
          if (waitrequest) d_readdata = ERR_READDATA;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter.
// Define ARB_ROUND_ROBIN_EN to check the round-robin grant order.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_writedata  (d_writedata),
    .d_byteenable (d_byteenable),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .bus_error    (bus_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_address = '0; i_read = 0;
    d_address = '0; d_read = 0; d_write = 0;
    d_writedata = '0; d_byteenable = '0;
    waitrequest = 0; readdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_read", {31'd0, read}, 0);
    chk("rst_write", {31'd0, write}, 0);
    chk("rst_be", {28'd0, byteenable}, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_berr", {31'd0, bus_error}, 0);
    chk("rst_iwait", {31'd0, i_waitrequest}, 0);
    chk("rst_dwait", {31'd0, d_waitrequest}, 0);

    // Single instruction fetch, zero wait states.
    i_read = 1; i_address = 32'hBFC00000; readdata = 32'hCAFE0001;
    #1;
    chk("if_idle_wait", {31'd0, i_waitrequest}, 1);
    chk("if_idle_read", {31'd0, read}, 0);
    step();
    chk("if_read", {31'd0, read}, 1);
    chk("if_addr", address, 32'hBFC00000);
    chk("if_wait", {31'd0, i_waitrequest}, 0);
    chk("if_rdata", i_readdata, 32'hCAFE0001);
    i_read = 0;
    step();
    chk("if_back_idle", {31'd0, read}, 0);
    chk("if_idle_addr", address, 0);

    // Simultaneous i and d: d first, i two cycles later.
    i_read = 1; i_address = 32'h2000;
    d_read = 1; d_address = 32'h1000; readdata = 32'h0D0D0D0D;
    step();
    chk("pri_d_addr", address, 32'h1000);
    chk("pri_d_wait", {31'd0, d_waitrequest}, 0);
    chk("pri_d_rdata", d_readdata, 32'h0D0D0D0D);
    chk("pri_i_held", {31'd0, i_waitrequest}, 1);
    d_read = 0;
    step();
    chk("pri_gap_read", {31'd0, read}, 0);
    chk("pri_gap_iwait", {31'd0, i_waitrequest}, 1);
    step();
    chk("pri_i_addr", address, 32'h2000);
    chk("pri_i_read", {31'd0, read}, 1);
    chk("pri_i_wait", {31'd0, i_waitrequest}, 0);
    i_read = 0;
    step();
    chk("pri_idle", {31'd0, read}, 0);

    // Both held for four transactions.
    i_read = 1; d_read = 1;
    for (int t = 0; t < 4; t++) begin
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("order", address, (t % 2 == 0) ? 32'h1000 : 32'h2000);
`else
      chk("order", address, 32'h1000);
`endif
      step();
    end
    i_read = 0; d_read = 0;
    step();

    // Write stretched by three wait states.
    d_write = 1; d_address = 32'h40; d_writedata = 32'h12345678;
    d_byteenable = 4'b0011; waitrequest = 1;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        waitrequest = 0;
        #1;
      end
      chk("wr_write", {31'd0, write}, 1);
      chk("wr_wdata", writedata, 32'h12345678);
      chk("wr_be", {28'd0, byteenable}, 32'h3);
      chk("wr_dwait", {31'd0, d_waitrequest}, (k < 3) ? 1 : 0);
      if (k < 3) step();
    end
    d_write = 0;
    step();
    chk("wr_idle", {31'd0, write}, 0);

    // Illegal read+write: write wins, read suppressed.
    d_read = 1; d_write = 1;
    step();
    chk("rw_write", {31'd0, write}, 1);
    chk("rw_read", {31'd0, read}, 0);
    d_read = 0; d_write = 0;
    step();

    // Stuck bus: forced completion on wait cycle 16.
    d_read = 1; waitrequest = 1;
    step();
    for (int k = 1; k < 16; k++) begin
      chk("to_wait", {31'd0, d_waitrequest}, 1);
      step();
    end
    chk("to_done", {31'd0, d_waitrequest}, 0);
    chk("to_rdata", d_readdata, 32'hDEADBEEF);
    chk("to_berr_pre", {31'd0, bus_error}, 0);
    d_read = 0;
    step();
    chk("to_berr", {31'd0, bus_error}, 1);
    chk("to_drop", {31'd0, read}, 0);
    waitrequest = 0; i_read = 1;
    step(); step(); i_read = 0; step();
    chk("to_sticky", {31'd0, bus_error}, 1);

    // Reset in the middle of a data grant.
    d_read = 1; waitrequest = 1;
    step();
    chk("rg_read", {31'd0, read}, 1);
    reset = 1; waitrequest = 0;
    #1;
    chk("rg_no_cmpl", {31'd0, d_waitrequest}, 1);
    step();
    chk("rg_read0", {31'd0, read}, 0);
    chk("rg_write0", {31'd0, write}, 0);
    chk("rg_berr", {31'd0, bus_error}, 0);
    chk("rg_dwait", {31'd0, d_waitrequest}, 1);
    reset = 0; d_read = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
